// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: register map, bit positions, FSM encoding.
package spi_target_pkg;

  localparam logic [11:0] REG_CONFIG = 12'h000;
  localparam logic [11:0] REG_STATUS = 12'h004;
  localparam logic [11:0] REG_RX     = 12'h008;
  localparam logic [11:0] REG_TX     = 12'h00C;

  localparam int CFG_CPOL           = 0;
  localparam int CFG_CPHA           = 1;
  localparam int CFG_MSB_FIRST      = 2;
  localparam int CFG_ACTIVE_HIGH_CS = 3;
  localparam int CFG_ENABLE         = 4;

  localparam int STS_SELECTED   = 0;
  localparam int STS_RX_VALID   = 1;
  localparam int STS_RX_OVERRUN = 2;
  localparam int STS_TX_EMPTY   = 3;

  localparam logic [4:0] CONFIG_DEFAULT = 5'h04;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/spi_target_if.sv
// Peripheral bus bundle between the CPU side (master) and the SPI target (slave).
interface spi_target_if;
  import spi_target_pkg::*;

  logic        peripheralEnable;
  logic        peripheralBus_we;
  logic        peripheralBus_oe;
  logic        peripheralBus_busy;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite;
  logic [31:0] peripheralBus_dataRead;
  logic        requestOutput;

  modport master (
    output peripheralEnable, peripheralBus_we, peripheralBus_oe,
           peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
    input  peripheralBus_busy, peripheralBus_dataRead, requestOutput
  );

  modport slave (
    input  peripheralEnable, peripheralBus_we, peripheralBus_oe,
           peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
    output peripheralBus_busy, peripheralBus_dataRead, requestOutput
  );

endinterface

// File: rtl/spi_target_sync.sv
// Multi-flop synchroniser for an asynchronous pad input, followed by one
// history flop so rising/falling edges can be flagged for a single clk cycle.
module spi_target_sync
  import spi_target_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   sync_w;
  logic              prev_q;

  assign sync_w  = {sync_q, d_i};
  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

  // Shift the pad value through the chain and remember the last synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_w[STAGES-1:0];
      prev_q <= level_o;
    end
  end

endmodule

// File: rtl/spi_target.sv
// Byte-oriented SPI target with config/status/RX/TX registers on the peripheral bus.
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [3:0] ID          = 4'h0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_target_if.slave  bus,
  input  logic         spi_clk,
  input  logic         spi_cs,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         spi_miso_en
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(spi_clk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(spi_cs),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic [4:0] config_q;
  logic       rx_valid_q, rx_overrun_q, tx_empty_q;
  logic [7:0] rx_buf_q, tx_buf_q, shift_q;
  logic [2:0] cnt_q;
  logic       miso_q, hold_q;
  state_e     state_q, state_d;

  logic cpol, cpha, msb_first, enable;
  assign cpol      = config_q[CFG_CPOL];
  assign cpha      = config_q[CFG_CPHA];
  assign msb_first = config_q[CFG_MSB_FIRST];
  assign enable    = config_q[CFG_ENABLE];

  logic cs_active, cs_begin, go, lead, trail, sample_edge, shift_edge, byte_done;
  logic [7:0] rx_byte, load_byte;
  assign cs_active   = config_q[CFG_ACTIVE_HIGH_CS] ? cs_lvl : ~cs_lvl;
  assign cs_begin    = config_q[CFG_ACTIVE_HIGH_CS] ? cs_rise : cs_fall;
  assign go          = cs_active & enable;
  assign lead        = cpol ? sclk_fall : sclk_rise;
  assign trail       = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail : lead;
  assign shift_edge  = cpha ? lead : trail;
  assign byte_done   = (state_q == S_ACTIVE) && go && sample_edge && (cnt_q == 3'd7);
  assign rx_byte     = msb_first ? {shift_q[6:0], mosi_lvl} : {mosi_lvl, shift_q[7:1]};
  assign load_byte   = tx_empty_q ? 8'hFF : tx_buf_q;

  // Bus decode; only byte lane 0 carries register data.
  logic        dev_sel, reg_hit, wr_en, rd_rx;
  logic [11:0] local_addr;
  logic [7:0]  rd_val;
  logic        unused_bus_bits;
  assign dev_sel    = bus.peripheralEnable && (bus.peripheralBus_address[15:12] == ID);
  assign local_addr = bus.peripheralBus_address[11:0];
  assign wr_en      = dev_sel && bus.peripheralBus_we && bus.peripheralBus_byteSelect[0];
  assign unused_bus_bits = ^{bus.peripheralBus_byteSelect[3:1], bus.peripheralBus_dataWrite[31:8]};

  // Register read mux; TX reads back as zero.
  always_comb begin
    reg_hit = 1'b1;
    rd_val  = 8'h00;
    case (local_addr)
      REG_CONFIG: rd_val = {3'b000, config_q};
      REG_STATUS: rd_val = {4'h0, tx_empty_q, rx_overrun_q, rx_valid_q, state_q != S_IDLE};
      REG_RX:     rd_val = rx_buf_q;
      REG_TX:     rd_val = 8'h00;
      default:    reg_hit = 1'b0;
    endcase
  end

  assign bus.requestOutput          = dev_sel && bus.peripheralBus_oe && reg_hit;
  assign bus.peripheralBus_dataRead = bus.requestOutput ? {24'h0, rd_val} : 32'hFFFF_FFFF;
  assign bus.peripheralBus_busy     = 1'b0;
  assign rd_rx                      = bus.requestOutput && (local_addr == REG_RX);

  // FSM next state and pad enable; losing CS or enable always returns to IDLE.
  always_comb begin
    state_d     = state_q;
    spi_miso_en = 1'b0;
    case (state_q)
      S_IDLE:   if (cs_begin && enable) state_d = S_LOAD;
      S_LOAD:   state_d = S_ACTIVE;
      S_ACTIVE: if (byte_done) state_d = S_LOAD;
      default:  state_d = S_IDLE;
    endcase
    if (!go) state_d = S_IDLE;
    if (state_q != S_IDLE && go) spi_miso_en = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Shift datapath. hold_q suppresses the first shift edge after LOAD when it
  // arrives before any sample edge, so the preloaded bit is not skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      miso_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: cnt_q <= 3'd0;
        S_LOAD: begin
          shift_q <= load_byte;
          miso_q  <= msb_first ? load_byte[7] : load_byte[0];
          hold_q  <= 1'b1;
          cnt_q   <= 3'd0;
        end
        S_ACTIVE: begin
          if (go && sample_edge) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            hold_q  <= 1'b0;
          end else if (go && shift_edge) begin
            if (!hold_q) miso_q <= msb_first ? shift_q[7] : shift_q[0];
            hold_q <= 1'b0;
          end
        end
        default: cnt_q <= 3'd0;
      endcase
    end
  end

  // CPU-visible registers; hardware set events win over same-cycle CPU clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      config_q     <= CONFIG_DEFAULT;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_empty_q   <= 1'b1;
      rx_buf_q     <= 8'h00;
      tx_buf_q     <= 8'h00;
    end else begin
      if (wr_en && local_addr == REG_CONFIG) config_q <= bus.peripheralBus_dataWrite[4:0];
      if (wr_en && local_addr == REG_TX) begin
        tx_buf_q   <= bus.peripheralBus_dataWrite[7:0];
        tx_empty_q <= 1'b0;
      end else if (state_q == S_LOAD) begin
        tx_empty_q <= 1'b1;
      end
      if (byte_done) begin
        rx_buf_q   <= rx_byte;
        rx_valid_q <= 1'b1;
      end else if (rd_rx) begin
        rx_valid_q <= 1'b0;
      end
      if (byte_done && rx_valid_q) rx_overrun_q <= 1'b1;
      else if (wr_en && local_addr == REG_STATUS && bus.peripheralBus_dataWrite[STS_RX_OVERRUN])
        rx_overrun_q <= 1'b0;
    end
  end

  assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bus register access plus SPI frames in several modes.
module tb_spi_target;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst;
  logic spi_clk, spi_cs, spi_mosi, spi_miso, spi_miso_en;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_target_if bus_if ();

  spi_target #(.ID(4'h0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_en(spi_miso_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.peripheralEnable         = 1'b1;
    bus_if.peripheralBus_we         = 1'b1;
    bus_if.peripheralBus_address    = a;
    bus_if.peripheralBus_byteSelect = 4'h1;
    bus_if.peripheralBus_dataWrite  = d;
    @(negedge clk);
    bus_if.peripheralEnable = 1'b0;
    bus_if.peripheralBus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic req);
    @(negedge clk);
    bus_if.peripheralEnable      = 1'b1;
    bus_if.peripheralBus_oe      = 1'b1;
    bus_if.peripheralBus_address = a;
    #1;
    d   = bus_if.peripheralBus_dataRead;
    req = bus_if.requestOutput;
    @(negedge clk);
    bus_if.peripheralEnable = 1'b0;
    bus_if.peripheralBus_oe = 1'b0;
  endtask

  // One CS-framed transfer of nbits, CS active low; returns the MISO bits seen
  // at the controller's sample points and how often the pad was enabled there.
  task automatic spi_frame(input logic cpol, input logic cpha, input logic msb,
                           input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output int en_cnt);
    int idx;
    rx = 8'h00;
    en_cnt = 0;
    spi_clk = cpol;
    repeat (4) @(negedge clk);
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? 7 - i : i;
      if (!cpha) begin
        spi_mosi = tx[idx];
        repeat (HALF) @(negedge clk);
        rx[idx] = spi_miso;
        if (spi_miso_en) en_cnt++;
        spi_clk = ~cpol;
        repeat (HALF) @(negedge clk);
        spi_clk = cpol;
      end else begin
        spi_clk  = ~cpol;
        spi_mosi = tx[idx];
        repeat (HALF) @(negedge clk);
        rx[idx] = spi_miso;
        if (spi_miso_en) en_cnt++;
        spi_clk = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        req;
    logic [7:0]  miso_byte;
    int          en_cnt;

    rst = 1'b1;
    spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    bus_if.peripheralEnable = 1'b0; bus_if.peripheralBus_we = 1'b0;
    bus_if.peripheralBus_oe = 1'b0; bus_if.peripheralBus_address = 16'h0;
    bus_if.peripheralBus_byteSelect = 4'h0; bus_if.peripheralBus_dataWrite = 32'h0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Reset state
    check("rst_miso", {31'h0, spi_miso}, 32'h0);
    check("rst_miso_en", {31'h0, spi_miso_en}, 32'h0);
    check("rst_busy", {31'h0, bus_if.peripheralBus_busy}, 32'h0);
    check("idle_dataRead", bus_if.peripheralBus_dataRead, 32'hFFFF_FFFF);
    bus_read(16'h0000, rd, req);
    check("rst_config", rd, 32'h04);
    check("rst_config_req", {31'h0, req}, 32'h1);
    bus_read(16'h0004, rd, req);
    check("rst_status", rd, 32'h08);

    // Mode 0, msbFirst, TX=0xA5, controller sends 0x3C
    bus_write(16'h0000, 32'h14);
    bus_write(16'h000C, 32'hA5);
    bus_read(16'h0004, rd, req);
    check("m0_status_txfull", rd, 32'h00);
    spi_frame(1'b0, 1'b0, 1'b1, 8'h3C, 8, miso_byte, en_cnt);
    check("m0_miso", {24'h0, miso_byte}, 32'hA5);
    check("m0_en_cnt", en_cnt, 32'd8);
    check("m0_en_after", {31'h0, spi_miso_en}, 32'h0);
    bus_read(16'h0004, rd, req);
    check("m0_status_rx", rd, 32'h0A);
    bus_read(16'h0008, rd, req);
    check("m0_rx", rd, 32'h3C);
    bus_read(16'h0004, rd, req);
    check("m0_status_cleared", rd, 32'h08);

    // Mode 3, lsbFirst, TX empty, send 0x81
    bus_write(16'h0000, 32'h13);
    spi_clk = 1'b1;
    repeat (6) @(negedge clk);
    spi_frame(1'b1, 1'b1, 1'b0, 8'h81, 8, miso_byte, en_cnt);
    check("m3_miso", {24'h0, miso_byte}, 32'hFF);
    bus_read(16'h0008, rd, req);
    check("m3_rx", rd, 32'h81);

    // Overrun: two bytes without reading RX
    bus_write(16'h0000, 32'h14);
    spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    spi_frame(1'b0, 1'b0, 1'b1, 8'h11, 8, miso_byte, en_cnt);
    spi_frame(1'b0, 1'b0, 1'b1, 8'h22, 8, miso_byte, en_cnt);
    bus_read(16'h0004, rd, req);
    check("ovr_status", rd, 32'h0E);
    bus_read(16'h0008, rd, req);
    check("ovr_rx", rd, 32'h22);
    bus_write(16'h0004, 32'h04);
    bus_read(16'h0004, rd, req);
    check("ovr_cleared", rd, 32'h08);

    // CS dropped after 5 bits, then a clean byte
    spi_frame(1'b0, 1'b0, 1'b1, 8'hF0, 5, miso_byte, en_cnt);
    check("abort_en_cnt", en_cnt, 32'd5);
    check("abort_en_after", {31'h0, spi_miso_en}, 32'h0);
    bus_read(16'h0004, rd, req);
    check("abort_status", rd, 32'h08);
    spi_frame(1'b0, 1'b0, 1'b1, 8'h5A, 8, miso_byte, en_cnt);
    bus_read(16'h0008, rd, req);
    check("after_abort_rx", rd, 32'h5A);

    // Disabled: no pad enable, no reception; decode boundaries
    bus_write(16'h0000, 32'h04);
    spi_frame(1'b0, 1'b0, 1'b1, 8'h77, 8, miso_byte, en_cnt);
    check("dis_en_cnt", en_cnt, 32'd0);
    bus_read(16'h0004, rd, req);
    check("dis_status", rd, 32'h08);
    bus_read(16'h0010, rd, req);
    check("unmapped_data", rd, 32'hFFFF_FFFF);
    check("unmapped_req", {31'h0, req}, 32'h0);
    bus_read(16'h000C, rd, req);
    check("tx_readback", rd, 32'h00);
    bus_read(16'h1000, rd, req);
    check("other_id", rd, 32'hFFFF_FFFF);

    // Reset in the middle of a byte
    bus_write(16'h0000, 32'h14);
    bus_write(16'h000C, 32'hFF);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_miso", {31'h0, spi_miso}, 32'h1);
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_miso", {31'h0, spi_miso}, 32'h0);
    check("midrst_en", {31'h0, spi_miso_en}, 32'h0);
    bus_read(16'h0000, rd, req);
    check("midrst_config", rd, 32'h04);
    bus_read(16'h0004, rd, req);
    check("midrst_status", rd, 32'h08);
    spi_cs = 1'b1;
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
